shift_right_iter: RTL and testbench
===================================

// Module: shift_right_iter
// PURPOSE
//  Multi-cycle right shifter (LSR/ASR) with a valid/ready handshake on both sides.
//  Counterpart of the datapath's combinational left shifter. Used by the pipelined
//  CPU's execute-stage multi-cycle unit for register-amount shifts.
//  Shifts STEP bits per cycle, which trades latency for area.
// PARAMETERS
//  WIDTH  64  data width in bits
//  STEP   1   max bits shifted per cycle; legal values 1,2,4,8
// PORTS
//  clk        in   1        single clock; all state updates on posedge
//  reset      in   1        synchronous, active-high
//  in_valid   in   1        request present
//  in_ready   out  1        unit can accept a request
//  in_data    in   WIDTH    operand
//  shamt      in   SHAMT_W  shift amount, SHAMT_W = $clog2(WIDTH)
//  arith      in   1        1 = ASR (sign fill), 0 = LSR (zero fill)
//  out_valid  out  1        result present
//  out_ready  in   1        consumer accepts result
//  out_data   out  WIDTH    shifted result
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out_data=0, internal count=0.
//    in_ready=0 while reset is high.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE:
//    IDLE:  in_ready=1. If in_valid=1, latch in_data, shamt and arith.
//           Next state is SHIFT if shamt!=0, else DONE.
//    SHIFT: in_ready=0. Each cycle: data >>= n, with n = min(STEP, remaining);
//           remaining -= n. Fill bit = arith ? latched MSB : 0.
//           Go to DONE on the cycle remaining reaches 0.
//    DONE:  out_valid=1 and out_data is held stable. If out_ready=1, go to IDLE.
//           A new request is accepted only once back in IDLE.
//           No bypass from DONE to SHIFT.
//  - Latency: out_valid rises 1 + ceil(shamt/STEP) cycles after the accept edge.
//    shamt=0 gives 1 cycle, with out_data = in_data.
//  - Input changes after the accept edge have no effect on the result.
//  - Backpressure: with out_ready=0, the unit stays in DONE indefinitely and holds
//    out_data.
//  - Reset mid-operation: abandon the request; IDLE and out_valid=0 on the next edge.
//  - shamt=WIDTH-1 is the maximum. No shamt value is illegal.
//  - out_data is a register, not combinational from the inputs.
// CONFIGURATION
//  - Macro SHIFT_RIGHT_ROR_EN.
//  - Defined:
//    - Adds input port "rotate" (1 bit), latched at accept like arith.
//    - rotate=1 selects ROR: bits leaving the LSB enter at the MSB.
//    - rotate takes priority over arith.
//  - Undefined:
//    - No rotate port.
//    - The fill bit is only zero or the sign bit.
// STRUCTURE
//  - Package shift_pkg:
//    - typedef enum logic[1:0] {S_IDLE, S_SHIFT, S_DONE} shr_state_t
//    - typedef enum {OP_LSR, OP_ASR, OP_ROR} shr_op_t
//    - function shamt_w(width) = $clog2(width)
//  - Sub-module shift_right_step (combinational):
//    - Inputs: data, n (0..STEP), op. Output: data shifted right by n.
//    - Instantiated once. The FSM and the counter stay in shift_right_iter.
// TESTING
//  - All cases use WIDTH=64, STEP=1 unless stated.
//  1. LSR: in=64'h8000_0000_0000_0000, shamt=4, arith=0 -> out_data=64'h0800_0000_0000_0000;
//     out_valid 5 cycles after accept.
//  2. ASR: in=64'hF000_0000_0000_0000, shamt=8, arith=1 -> out=64'hFFF0_0000_0000_0000.
//     Repeat with STEP=4: out_valid 3 cycles after accept.
//  3. shamt=0: in=64'd1023 -> out=64'd1023, out_valid 1 cycle after accept.
//  4. LSR all-ones by 63 -> out=64'd1. Hold out_ready=0 for 3 cycles: out_valid and
//     out_data stay stable, in_ready=0. Then out_ready=1 -> IDLE and in_ready=1 next cycle.
//  5. Assert reset during cycle 3 of a shamt=10 shift -> next cycle out_valid=0,
//     in_ready=0. After reset drops, in_ready=1 and a fresh request completes correctly.
//  6. With SHIFT_RIGHT_ROR_EN defined: in=64'd1, shamt=1, rotate=1
//     -> out=64'h8000_0000_0000_0000. With rotate=1 and arith=1 the result is still ROR.

Source files
------------

// File: rtl/shift_right_iter_pkg.sv
// rtl/shift_right_iter_pkg.sv - shared types and width helper for the iterative right shifter
package shift_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shr_state_t;

  typedef enum {OP_LSR, OP_ASR, OP_ROR} shr_op_t;

  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_right_iter_if.sv
// rtl/shift_right_iter_if.sv - request/result handshake bundle; rotate exists only with SHIFT_RIGHT_ROR_EN
interface shift_right_iter_if #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = shift_pkg::shamt_w(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
`ifdef SHIFT_RIGHT_ROR_EN
  logic               rotate;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, shamt, arith,
`ifdef SHIFT_RIGHT_ROR_EN
    output rotate,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, shamt, arith,
`ifdef SHIFT_RIGHT_ROR_EN
    input  rotate,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_right_iter_step.sv
// rtl/shift_right_iter_step.sv - combinational right shift by a small amount with zero, sign or rotate fill
module shift_right_step
  import shift_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = shamt_w(WIDTH)
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] n_i,
  input  shr_op_t            op_i,
  output logic [WIDTH-1:0]   data_o
);

  logic [WIDTH-1:0]   fill;
  logic [2*WIDTH-1:0] shifted;

  // The upper half supplies the bits that enter from the MSB side.
  always_comb begin
    case (op_i)
      OP_ASR:  fill = {WIDTH{data_i[WIDTH-1]}};
      OP_ROR:  fill = data_i;
      default: fill = '0;
    endcase
    shifted = {fill, data_i} >> n_i;
    data_o  = shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/shift_right_iter.sv
// rtl/shift_right_iter.sv - multi-cycle LSR/ASR shifter, STEP bits per cycle; ROR added by SHIFT_RIGHT_ROR_EN
module shift_right_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input logic              clk,
  input logic              reset,
  shift_right_iter_if.slave bus
);

  localparam int SHAMT_W = shamt_w(WIDTH);
  // When STEP cannot be represented in the counter width, every remaining amount fits in one step.
  localparam bit                 STEP_BIG = (STEP >= WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_V   = STEP_BIG ? '0 : SHAMT_W'(STEP);

  shr_state_t         state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  shr_op_t            op_q, op_d;
  shr_op_t            op_in;
  logic [SHAMT_W-1:0] step_n;
  logic [WIDTH-1:0]   step_data;

  always_comb begin
`ifdef SHIFT_RIGHT_ROR_EN
    if (bus.rotate)     op_in = OP_ROR;
    else if (bus.arith) op_in = OP_ASR;
    else                op_in = OP_LSR;
`else
    op_in = bus.arith ? OP_ASR : OP_LSR;
`endif
  end

  assign step_n = (STEP_BIG || (rem_q < STEP_V)) ? rem_q : STEP_V;

  shift_right_step #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_step (
    .data_i(data_q),
    .n_i   (step_n),
    .op_i  (op_q),
    .data_o(step_data)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          rem_d   = bus.shamt;
          op_d    = op_in;
          state_d = (bus.shamt != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        data_d = step_data;
        rem_d  = rem_q - step_n;
        if (rem_q == step_n) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= OP_LSR;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !reset;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_shift_right_iter.sv
// tb/tb_shift_right_iter.sv - directed checks of the iterative right shifter at STEP=1 and STEP=4
module tb_shift_right_iter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  shift_right_iter_if #(.WIDTH(64)) bus_a ();
  shift_right_iter_if #(.WIDTH(64)) bus_b ();

  shift_right_iter #(.WIDTH(64), .STEP(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  shift_right_iter #(.WIDTH(64), .STEP(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issue one request on the STEP=1 unit, scramble inputs after accept, check latency and result.
  task automatic run_a(input string tag, input logic [63:0] d, input logic [5:0] sh,
                       input logic ar, input logic [63:0] exp_d, input int exp_lat);
    int g;
    int lat;
    g = 0;
    while (!bus_a.in_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.shamt    = sh;
    bus_a.arith    = ar;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = ~d;
    bus_a.shamt    = ~sh;
    bus_a.arith    = ~ar;
    lat = 1;
    while (!bus_a.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, bus_a.out_data, exp_d);
  endtask

  task automatic release_a();
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.shamt = '0; bus_a.arith = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.shamt = '0; bus_b.arith = 1'b0; bus_b.out_ready = 1'b0;
`ifdef SHIFT_RIGHT_ROR_EN
    bus_a.rotate = 1'b0;
    bus_b.rotate = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_out_data", bus_a.out_data, 64'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 64'(bus_a.in_ready), 64'd1);

    run_a("lsr4", 64'h8000_0000_0000_0000, 6'd4, 1'b0, 64'h0800_0000_0000_0000, 5);
    release_a();
    run_a("asr8", 64'hF000_0000_0000_0000, 6'd8, 1'b1, 64'hFFF0_0000_0000_0000, 9);
    release_a();
    run_a("sh0", 64'd1023, 6'd0, 1'b0, 64'd1023, 1);
    release_a();
    run_a("asr_pos", 64'h7000_0000_0000_0000, 6'd4, 1'b1, 64'h0700_0000_0000_0000, 5);
    release_a();
    run_a("asr63", 64'h8000_0000_0000_0000, 6'd63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    release_a();

    run_a("lsr63", 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b0, 64'd1, 64);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
      check("bp_out_data", bus_a.out_data, 64'd1);
      check("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
    end
    release_a();
    check("rel_in_ready", 64'(bus_a.in_ready), 64'd1);
    check("rel_out_valid", 64'(bus_a.out_valid), 64'd0);

    // STEP=4 unit
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 64'hF000_0000_0000_0000;
    bus_b.shamt    = 6'd8;
    bus_b.arith    = 1'b1;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = '0;
    bus_b.arith    = 1'b0;
    lat = 1;
    while (!bus_b.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("s4_asr8_lat", 64'(lat), 64'd3);
    check("s4_asr8_data", bus_b.out_data, 64'hFFF0_0000_0000_0000);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 64'hFFFF_0000_0000_0000;
    bus_b.shamt    = 6'd7;
    bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    check("s4_no_accept_in_done", 64'(bus_b.in_ready), 64'd1);
    bus_b.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    lat = 1;
    while (!bus_b.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("s4_lsr7_lat", 64'(lat), 64'd3);
    check("s4_lsr7_data", bus_b.out_data, 64'h01FF_FE00_0000_0000);
    bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.out_ready = 1'b0;

    // Reset during the third shift cycle
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus_a.shamt    = 6'd10;
    bus_a.arith    = 1'b0;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus_a.in_ready), 64'd0);
    check("mid_rst_out_data", bus_a.out_data, 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    run_a("post_rst", 64'h1234_5678_9ABC_DEF0, 6'd4, 1'b0, 64'h0123_4567_89AB_CDEF, 5);
    release_a();

`ifdef SHIFT_RIGHT_ROR_EN
    bus_a.rotate = 1'b1;
    run_a("ror1", 64'd1, 6'd1, 1'b0, 64'h8000_0000_0000_0000, 2);
    release_a();
    run_a("ror_over_asr", 64'd3, 6'd4, 1'b1, 64'h3000_0000_0000_0000, 5);
    release_a();
    bus_a.rotate = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
